// File: rtl/counter_seq_ctrl_if.sv
// Bundle between the counter sequencer and the board keys/switches/counter.
// master = sequencer side, slave = board and counter side.
interface counter_seq_ctrl_if;
    logic       key_step_n;
    logic       key_clr_n;
    logic       sw_run;
    logic [2:0] sw_mod;
    logic [3:0] q;
    logic       cnt_en;
    logic       cnt_clr;
    logic [2:0] mod_sel;
    logic [1:0] state;
    logic       wrap;
    logic [7:0] wrap_cnt;

    modport master (
        input  key_step_n,
        input  key_clr_n,
        input  sw_run,
        input  sw_mod,
        input  q,
        output cnt_en,
        output cnt_clr,
        output mod_sel,
        output state,
        output wrap,
        output wrap_cnt
    );

    modport slave (
        output key_step_n,
        output key_clr_n,
        output sw_run,
        output sw_mod,
        output q,
        input  cnt_en,
        input  cnt_clr,
        input  mod_sel,
        input  state,
        input  wrap,
        input  wrap_cnt
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Key debounce, run/pause/step FSM, modulus latch and wrap reporting.
// Define CTRL_AUTOSTOP_EN to pause RUN after STOP_WRAPS wraps.
module counter_seq_ctrl_deb #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic cp,
    input  logic clr,
    input  logic key_n,
    output logic press
);
    localparam int CW = ($clog2(DEB_CYCLES) < 1) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge cp) begin
        if (clr) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CMAX) begin
                // Level flips only after DEB_CYCLES consecutive differing samples
                cnt   <= '0;
                level <= s2;
                press <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module counter_seq_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int TICK_DIV   = 50000000,
    parameter int STOP_WRAPS = 4
) (
    input logic               cp,
    input logic               clr,
    counter_seq_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam int TW = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    state_t        state;
    logic [TW-1:0] tick;
    logic          cnt_en;
    logic          cnt_clr;
    logic          cnt_en_d;
    logic          wrap;
    logic [7:0]    wrap_cnt;
    logic [2:0]    mod_sel;
    logic          step_press;
    logic          clr_press;
    logic          wrap_now;
    logic          auto_stop;
    logic          stop_lock;

    counter_seq_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .cp    (cp),
        .clr   (clr),
        .key_n (bus.key_step_n),
        .press (step_press)
    );

    counter_seq_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .cp    (cp),
        .clr   (clr),
        .key_n (bus.key_clr_n),
        .press (clr_press)
    );

    // Q reflects a count pulse one cycle late, so test it against the delayed enable
    assign wrap_now = cnt_en_d && (bus.q == 4'd0);

`ifdef CTRL_AUTOSTOP_EN
    logic [7:0] run_wraps;

    assign auto_stop = wrap_now && ((int'(run_wraps) + 1) >= STOP_WRAPS);

    always_ff @(posedge cp) begin
        if (clr || clr_press) begin
            run_wraps <= '0;
            stop_lock <= 1'b0;
        end else begin
            if (state != RUN) begin
                run_wraps <= '0;
            end else if (wrap_now && run_wraps != 8'hFF) begin
                run_wraps <= run_wraps + 8'd1;
            end
            if (!bus.sw_run) begin
                stop_lock <= 1'b0;
            end else if (state == RUN && auto_stop) begin
                stop_lock <= 1'b1;
            end
        end
    end
`else
    assign auto_stop = 1'b0;
    assign stop_lock = 1'b0;
`endif

    always_ff @(posedge cp) begin
        if (clr) begin
            state    <= IDLE;
            tick     <= '0;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            cnt_en_d <= 1'b0;
            wrap     <= 1'b0;
            wrap_cnt <= '0;
            mod_sel  <= bus.sw_mod;
        end else begin
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            cnt_en_d <= cnt_en;
            wrap     <= wrap_now;
            if (wrap_now && wrap_cnt != 8'hFF) begin
                wrap_cnt <= wrap_cnt + 8'd1;
            end
            if (clr_press) begin
                cnt_clr  <= 1'b1;
                cnt_en_d <= 1'b0;
                state    <= IDLE;
                tick     <= '0;
                wrap_cnt <= '0;
                mod_sel  <= bus.sw_mod;
            end else begin
                unique case (state)
                    IDLE: begin
                        mod_sel <= bus.sw_mod;
                        tick    <= '0;
                        state   <= bus.sw_run ? RUN : PAUSE;
                    end
                    RUN: begin
                        if (wrap_now) begin
                            mod_sel <= bus.sw_mod;
                        end
                        if (!bus.sw_run || auto_stop) begin
                            state <= PAUSE;
                            tick  <= '0;
                        end else if (tick == TICK_MAX) begin
                            cnt_en <= 1'b1;
                            tick   <= '0;
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (wrap_now) begin
                            mod_sel <= bus.sw_mod;
                        end
                        if (bus.sw_run && !stop_lock) begin
                            state <= RUN;
                            tick  <= '0;
                        end else if (step_press) begin
                            cnt_en <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.cnt_en   = cnt_en;
    assign bus.cnt_clr  = cnt_clr;
    assign bus.mod_sel  = mod_sel;
    assign bus.state    = state;
    assign bus.wrap     = wrap;
    assign bus.wrap_cnt = wrap_cnt;
endmodule
